fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the next generation of the team's byte FIFO: configurable data width and depth (not restricted to powers of two), programmable almost-full/almost-empty thresholds, a run-time selectable overflow policy, registered read data with a valid strobe, and sticky error flags. It sits between a producer and a consumer in the same clock domain. It replaces the fixed 8-bit FIFO wherever backpressure status or overflow reporting is needed.

---
 rtl/fifo_flex_pkg.sv | 14 +
 rtl/fifo_flex_wrap_ptr.sv | 24 ++
 rtl/fifo_flex.sv | 135 +++++++++++++
 tb/tb_fifo_flex.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// rtl/fifo_flex_pkg.sv - shared types and width helper for the flexible FIFO
package fifo_flex_pkg;

   typedef enum logic {
      DROP_NEW  = 1'b0,
      OVERWRITE = 1'b1
   } ovf_mode_e;

   // Occupancy must represent 0..depth inclusive, hence depth+1 states.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_flex_wrap_ptr.sv
// rtl/fifo_flex_wrap_ptr.sv - modulo-DEPTH pointer, wraps to 0 after DEPTH-1
module wrap_ptr #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   output logic [ADDR_W-1:0] o_ptr
);

   logic [ADDR_W-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised synchronous FIFO with thresholds, overflow policy
// and sticky error flags; occupancy is tracked solely by r_count.
module fifo_flex
   import fifo_flex_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int CNT_W    = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ovf_mode,
   input  logic              wen,
   input  logic [DATA_W-1:0] wdata,
   input  logic              ren,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              ovf_err,
   output logic              udf_err,
   input  logic              clr_err
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf_err;
   logic              r_udf_err;

   logic [ADDR_W-1:0] w_wptr;
   logic [ADDR_W-1:0] w_rptr;
   logic              w_full;
   logic              w_empty;
   logic              w_rd_acc;
   logic              w_wr_acc;
   logic              w_ovw;
   logic              w_rptr_inc;
   logic              w_cnt_up;
   logic              w_cnt_dn;
   ovf_mode_e         w_mode;

   assign w_mode  = ovf_mode_e'(ovf_mode);
   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // A simultaneous read on a full FIFO frees the slot, so the write is never an overflow.
   assign w_rd_acc   = ren && !w_empty;
   assign w_ovw      = wen && w_full && !ren && (w_mode == OVERWRITE);
   assign w_wr_acc   = wen && (!w_full || ren || (w_mode == OVERWRITE));
   assign w_rptr_inc = w_rd_acc || w_ovw;
   assign w_cnt_up   = w_wr_acc && !w_rptr_inc;
   assign w_cnt_dn   = w_rd_acc && !w_wr_acc;

   wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_wr_acc),
      .o_ptr (w_wptr)
   );

   wrap_ptr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_rptr_inc),
      .o_ptr (w_rptr)
   );

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[w_wptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_rdata   <= '0;
         r_rvalid  <= 1'b0;
         r_ovf_err <= 1'b0;
         r_udf_err <= 1'b0;
      end else begin
         if (w_cnt_up) begin
            r_count <= r_count + 1'b1;
         end else if (w_cnt_dn) begin
            r_count <= r_count - 1'b1;
         end
         r_rvalid <= w_rd_acc;
         if (w_rd_acc) begin
            r_rdata <= r_mem[w_rptr];
         end
         if (wen && w_full && !ren) begin
            r_ovf_err <= 1'b1;
         end else if (clr_err) begin
            r_ovf_err <= 1'b0;
         end
         if (ren && w_empty) begin
            r_udf_err <= 1'b1;
         end else if (clr_err) begin
            r_udf_err <= 1'b0;
         end
      end
   end

   assign rdata        = r_rdata;
   assign rvalid       = r_rvalid;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = rst_n && w_empty;
   assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
   assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
   assign ovf_err      = r_ovf_err;
   assign udf_err      = r_udf_err;

`ifdef FORMAL
   a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
      r_count <= CNT_W'(DEPTH));
   a_cnt_ptr: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(r_count) == (int'(w_wptr) + DEPTH - int'(w_rptr)) % DEPTH) ||
      (w_full && (w_wptr == w_rptr)));
   a_ptr_rng: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(w_wptr) < DEPTH) && (int'(w_rptr) < DEPTH));
   a_cnt_step: assert property (@(posedge clk) disable iff (!rst_n)
      (r_count == $past(r_count)) || (r_count == $past(r_count) + 1'b1) ||
      (r_count == $past(r_count) - 1'b1));
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - directed table-driven bench for fifo_flex
module tb_fifo_flex;

   logic        clk = 1'b0;
   logic        rst_n;

   // 16-deep, 8-bit instance
   logic        a_ovf, a_wen, a_ren, a_clr;
   logic [7:0]  a_wdata, a_rdata;
   logic        a_rvalid, a_full, a_empty, a_af, a_ae, a_oerr, a_uerr;
   logic [4:0]  a_count;

   // 5-deep, 12-bit instance
   logic        b_wen, b_ren;
   logic [11:0] b_wdata, b_rdata;
   logic        b_rvalid, b_full, b_empty, b_af, b_ae, b_oerr, b_uerr;
   logic [2:0]  b_count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fifo_flex #(.DATA_W(8), .DEPTH(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .ovf_mode(a_ovf), .wen(a_wen), .wdata(a_wdata),
      .ren(a_ren), .rdata(a_rdata), .rvalid(a_rvalid), .count(a_count),
      .full(a_full), .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
      .ovf_err(a_oerr), .udf_err(a_uerr), .clr_err(a_clr)
   );

   fifo_flex #(.DATA_W(12), .DEPTH(5)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .ovf_mode(1'b0), .wen(b_wen), .wdata(b_wdata),
      .ren(b_ren), .rdata(b_rdata), .rvalid(b_rvalid), .count(b_count),
      .full(b_full), .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
      .ovf_err(b_oerr), .udf_err(b_uerr), .clr_err(1'b0)
   );

   typedef struct {
      logic       wen;
      logic [7:0] wdata;
      logic       ren;
      logic       clr;
      int         cnt;
      logic       rv;
      logic [7:0] rd;
      logic       ae;
      logic       emp;
      logic       ue;
   } vec_t;

   vec_t tbl [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step_a(input logic wen, input logic [7:0] d, input logic ren,
                         input logic ovf, input logic clr);
      a_wen = wen; a_wdata = d; a_ren = ren; a_ovf = ovf; a_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic step_b(input logic wen, input logic [11:0] d, input logic ren);
      b_wen = wen; b_wdata = d; b_ren = ren;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] e;

      rst_n = 1'b1;
      a_ovf = 0; a_wen = 0; a_ren = 0; a_clr = 0; a_wdata = '0;
      b_wen = 0; b_ren = 0; b_wdata = '0;

      //             wen  wdata ren  clr cnt rv  rd     ae  emp ue
      tbl[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h44, 1'b1, 1'b0, 3, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h44, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};

      // Reset values while rst_n is low
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", a_count, 0);
      chk("rst_empty_gated", a_empty, 0);
      chk("rst_full", a_full, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("rst_rvalid", a_rvalid, 0);
      chk("rst_rdata", a_rdata, 0);
      chk("rst_errs", {a_oerr, a_uerr}, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rel_empty", a_empty, 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         step_a(tbl[i].wen, tbl[i].wdata, tbl[i].ren, 1'b0, tbl[i].clr);
         chk($sformatf("t%0d_count", i), a_count, tbl[i].cnt);
         chk($sformatf("t%0d_rvalid", i), a_rvalid, tbl[i].rv);
         chk($sformatf("t%0d_rdata", i), a_rdata, tbl[i].rd);
         chk($sformatf("t%0d_ae", i), a_ae, tbl[i].ae);
         chk($sformatf("t%0d_empty", i), a_empty, tbl[i].emp);
         chk($sformatf("t%0d_uerr", i), a_uerr, tbl[i].ue);
         chk($sformatf("t%0d_oerr", i), a_oerr, 0);
      end
      step_a(0, 0, 0, 0, 0);

      // Non-power-of-two depth: fill, drain, then again across the wrap
      for (int i = 1; i <= 5; i++) step_b(1, 12'(i), 0);
      chk("b_full", b_full, 1);
      chk("b_count", b_count, 5);
      for (int i = 1; i <= 5; i++) begin
         step_b(0, 0, 1);
         chk($sformatf("b_pop%0d", i), {b_rvalid, b_rdata}, {1'b1, 12'(i)});
      end
      chk("b_empty", b_empty, 1);
      step_b(1, 12'h006, 0);
      step_b(1, 12'h007, 0);
      step_b(0, 0, 1);
      chk("b_wrap6", {b_rvalid, b_rdata}, {1'b1, 12'h006});
      step_b(0, 0, 1);
      chk("b_wrap7", {b_rvalid, b_rdata}, {1'b1, 12'h007});
      step_b(0, 0, 0);
      chk("b_errs", {b_oerr, b_uerr, b_empty}, 3'b001);

      // Drop-new overflow
      for (int i = 0; i < 16; i++) begin
         step_a(1, 8'(8'h10 + i), 0, 0, 0);
         if (i == 12) chk("af_13", a_af, 0);
         if (i == 13) chk("af_14", a_af, 1);
      end
      chk("drop_full", a_full, 1);
      step_a(1, 8'hAA, 0, 0, 0);
      chk("drop_count", a_count, 16);
      chk("drop_oerr", a_oerr, 1);
      for (int i = 0; i < 16; i++) begin
         step_a(0, 0, 1, 0, 0);
         chk($sformatf("drop_pop%0d", i), {a_rvalid, a_rdata}, {1'b1, 8'(8'h10 + i)});
      end
      chk("drop_empty", a_empty, 1);
      chk("drop_oerr_sticky", a_oerr, 1);
      step_a(0, 0, 0, 0, 1);
      chk("drop_oerr_clr", a_oerr, 0);

      // Overwrite-oldest overflow
      for (int i = 0; i < 16; i++) step_a(1, 8'(i), 0, 1, 0);
      step_a(1, 8'hAA, 0, 1, 0);
      chk("ovw_count", a_count, 16);
      chk("ovw_oerr", a_oerr, 1);
      for (int i = 0; i < 16; i++) begin
         e = (i < 15) ? 8'(i + 1) : 8'hAA;
         step_a(0, 0, 1, 1, 0);
         chk($sformatf("ovw_pop%0d", i), {a_rvalid, a_rdata}, {1'b1, e});
      end
      step_a(0, 0, 0, 0, 1);
      chk("ovw_clr", a_oerr, 0);

      // Full FIFO with simultaneous read and write, both overflow modes
      for (int i = 0; i < 16; i++) begin
         step_a(1, 8'(8'h20 + i), 0, 0, 0);
         q.push_back(8'(8'h20 + i));
      end
      for (int k = 0; k < 20; k++) begin
         e = q.pop_front();
         q.push_back(8'(8'h40 + k));
         step_a(1, 8'(8'h40 + k), 1, (k >= 10), 0);
         chk($sformatf("rw_data%0d", k), {a_rvalid, a_rdata}, {1'b1, e});
         chk($sformatf("rw_count%0d", k), a_count, 16);
         chk($sformatf("rw_oerr%0d", k), a_oerr, 0);
      end
      for (int k = 0; k < 16; k++) begin
         e = q.pop_front();
         step_a(0, 0, 1, 0, 0);
         chk($sformatf("rw_drain%0d", k), a_rdata, e);
      end
      chk("rw_empty", a_empty, 1);

      // Asynchronous reset mid-stream with count=7 and ren high
      step_a(0, 0, 1, 0, 0);
      chk("pre_rst_uerr", a_uerr, 1);
      for (int i = 0; i < 8; i++) step_a(1, 8'(8'h60 + i), 0, 0, 0);
      step_a(0, 0, 1, 0, 0);
      chk("pre_rst_count", a_count, 7);
      chk("pre_rst_rvalid", a_rvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count", a_count, 0);
      chk("arst_rvalid", a_rvalid, 0);
      chk("arst_rdata", a_rdata, 0);
      chk("arst_empty", a_empty, 0);
      chk("arst_flags", {a_full, a_af, a_ae, a_oerr, a_uerr}, 5'b00100);
      a_ren = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rel2_empty", a_empty, 1);
      chk("rel2_ae", a_ae, 1);
      chk("rel2_count", a_count, 0);
      @(posedge clk);
      #1;
      step_a(0, 0, 1, 0, 0);
      chk("post_rst_pop", {a_rvalid, a_uerr, a_count}, {1'b0, 1'b1, 5'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
